// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: mnemonic codes,
// MIPS opcode/func constants, loader FSM encodings and word-packing helpers.
package instr_encoder_loader_pkg;

    // Mnemonic codes presented by the host; 20..31 are illegal.
    localparam logic [4:0] MN_AND  = 5'd0;
    localparam logic [4:0] MN_SUB  = 5'd1;
    localparam logic [4:0] MN_ADD  = 5'd2;
    localparam logic [4:0] MN_OR   = 5'd3;
    localparam logic [4:0] MN_SLT  = 5'd4;
    localparam logic [4:0] MN_MULT = 5'd5;
    localparam logic [4:0] MN_JR   = 5'd6;
    localparam logic [4:0] MN_SLL  = 5'd7;
    localparam logic [4:0] MN_SRL  = 5'd8;
    localparam logic [4:0] MN_LW   = 5'd9;
    localparam logic [4:0] MN_SW   = 5'd10;
    localparam logic [4:0] MN_BEQ  = 5'd11;
    localparam logic [4:0] MN_BNE  = 5'd12;
    localparam logic [4:0] MN_J    = 5'd13;
    localparam logic [4:0] MN_JAL  = 5'd14;
    localparam logic [4:0] MN_ADDI = 5'd15;
    localparam logic [4:0] MN_ANDI = 5'd16;
    localparam logic [4:0] MN_ORI  = 5'd17;
    localparam logic [4:0] MN_SLTI = 5'd18;
    localparam logic [4:0] MN_LI   = 5'd19;

    // Primary opcodes, identical to what the control unit decodes.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LI    = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes.
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    // Loader FSM encodings.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ENC   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    // One symbolic instruction as captured from the host port.
    typedef struct packed {
        logic [4:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

    function automatic logic [31:0] pack_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                           logic [4:0] shamt, logic [5:0] func);
        return {OP_RTYPE, rs, rt, rd, shamt, func};
    endfunction

    function automatic logic [31:0] pack_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                           logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] pack_j(logic [5:0] op, logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational packer: mnemonic plus raw fields -> 32-bit MIPS word and a
// legal flag. Fields the format does not use are forced to zero.
module instr_word_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Select the instruction format and its constant fields per mnemonic.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        word  = 32'h0;
        legal = 1'b1;
        case (mnem)
            MN_AND:  word = pack_r(rs, rt, rd, 5'd0, FN_AND);
            MN_SUB:  word = pack_r(rs, rt, rd, 5'd0, FN_SUB);
            MN_ADD:  word = pack_r(rs, rt, rd, 5'd0, FN_ADD);
            MN_OR:   word = pack_r(rs, rt, rd, 5'd0, FN_OR);
            MN_SLT:  word = pack_r(rs, rt, rd, 5'd0, FN_SLT);
            MN_MULT: word = pack_r(rs, rt, 5'd0, 5'd0, FN_MULT);
            MN_JR:   word = pack_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_SLL:  word = pack_r(5'd0, rt, rd, shamt, FN_SLL);
            MN_SRL:  word = pack_r(5'd0, rt, rd, shamt, FN_SRL);
            MN_LW:   word = pack_i(OP_LW, rs, rt, imm);
            MN_SW:   word = pack_i(OP_SW, rs, rt, imm);
            MN_BEQ:  word = pack_i(OP_BEQ, rs, rt, imm);
            MN_BNE:  word = pack_i(OP_BNE, rs, rt, imm);
            MN_ADDI: word = pack_i(OP_ADDI, rs, rt, imm);
            MN_ANDI: word = pack_i(OP_ANDI, rs, rt, imm);
            MN_ORI:  word = pack_i(OP_ORI, rs, rt, imm);
            MN_SLTI: word = pack_i(OP_SLTI, rs, rt, imm);
            MN_LI:   word = pack_i(OP_LI, 5'd0, rt, imm);
            MN_J:    word = pack_j(OP_J, target);
            MN_JAL:  word = pack_j(OP_JAL, target);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts symbolic instructions from a host port,
// encodes them and writes them to sequential instruction-memory words.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inValid,
    output logic                         inReady,
    input  logic [4:0]                   mnem,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   shamt,
    input  logic [15:0]                  imm,
    input  logic [25:0]                  target,
    input  logic                         clear,
    output logic                         memWe,
    output logic [31:0]                  memAddr,
    output logic [31:0]                  memData,
    output logic [$clog2(DEPTH+1)-1:0]   wordCount,
    output logic                         errPulse,
    output logic                         full
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEPTH - 1);

    logic [1:0]    state;
    logic [31:0]   pointer;
    instr_fields_t fields;
    logic [31:0]   enc_word;
    logic          enc_legal;

    instr_word_packer u_packer (
        .mnem   (fields.mnem),
        .rs     (fields.rs),
        .rt     (fields.rt),
        .rd     (fields.rd),
        .shamt  (fields.shamt),
        .imm    (fields.imm),
        .target (fields.target),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    // Handshake and status decode; rst_n gating keeps inReady low during reset.
    assign inReady = rst_n && (state == S_IDLE) && !clear;
    assign memWe   = (state == S_WRITE);
    assign full    = (state == S_FULL);

    // Loader FSM with capture, write-address/data and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pointer   <= BASE_ADDR;
            memAddr   <= BASE_ADDR;
            memData   <= 32'h0;
            wordCount <= '0;
            errPulse  <= 1'b0;
            fields    <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            errPulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        pointer   <= BASE_ADDR;
                        wordCount <= '0;
                    end else if (inValid) begin
                        fields <= '{mnem: mnem, rs: rs, rt: rt, rd: rd, shamt: shamt,
                                    imm: imm, target: target};
                        state  <= S_ENC;
                    end
                end
                S_ENC: begin
                    if (enc_legal) begin
                        memAddr <= pointer;
                        memData <= enc_word;
                        state   <= S_WRITE;
                    end else begin
                        errPulse <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    pointer   <= pointer + 32'd4;
                    wordCount <= wordCount + CW'(1);
                    state     <= (wordCount == LAST_COUNT) ? S_FULL : S_IDLE;
                end
                S_FULL: begin
                    if (clear) begin
                        pointer   <= BASE_ADDR;
                        wordCount <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader (DEPTH=4): directed instructions
// push expected {addr, data, sample cycle}; a monitor pops on every memWe.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    mnem, rs, rt, rd, shamt;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          clear;
    logic          mem_we;
    logic [31:0]   mem_addr, mem_data;
    logic [CW-1:0] word_count;
    logic          err_pulse;
    logic          full;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb[$];

    instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (in_valid),
        .inReady   (in_ready),
        .mnem      (mnem),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .imm       (imm),
        .target    (target),
        .clear     (clear),
        .memWe     (mem_we),
        .memAddr   (mem_addr),
        .memData   (mem_data),
        .wordCount (word_count),
        .errPulse  (err_pulse),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %h data %h with no write expected",
                         mem_addr, mem_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_addr"}, mem_addr, e.addr);
                check({e.name, "_data"}, mem_data, e.data);
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Present one instruction; push the expected write when one is due.
    task automatic send(input logic [4:0] m, input logic [4:0] f_rs, input logic [4:0] f_rt,
                        input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [15:0] f_imm,
                        input logic [25:0] f_tgt, input bit exp_write,
                        input logic [31:0] e_addr, input logic [31:0] e_data, input string name);
        int n;
        exp_t e;
        @(negedge clk);
        mnem = m; rs = f_rs; rt = f_rt; rd = f_rd; shamt = f_sh; imm = f_imm; target = f_tgt;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: inReady stayed 0 for 20 cycles, expected 1", name);
            in_valid = 1'b0;
            return;
        end
        if (exp_write) begin
            e.addr = e_addr; e.data = e_data; e.cyc = cyc + 2; e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait until the loader is back in IDLE or FULL (bounded).
    task automatic settle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && !full && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready && !full) begin
            tests++;
            fails++;
            $display("FAIL %s_settle: loader busy for 20 cycles, expected idle or full", name);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    initial begin
        int hits;
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        mnem = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
        #12;
        check("rst_memWe", 32'(mem_we), 32'd0);
        check("rst_memAddr", mem_addr, 32'h0);
        check("rst_memData", mem_data, 32'h0);
        check("rst_wordCount", 32'(word_count), 32'd0);
        check("rst_errPulse", 32'(err_pulse), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_inReady", 32'(in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Basic R-type with latency check.
        send(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0, 32'h00221820, "add");
        settle("add");
        check("add_wordCount", 32'(word_count), 32'd1);
        pulse_clear();
        check("clear_idle_wordCount", 32'(word_count), 32'd0);

        // I/J/LI sequence at consecutive addresses.
        send(MN_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 32'h0, 32'h8FA80004, "lw");
        send(MN_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 32'h4, 32'h08000010, "j");
        send(MN_LI, 5'd9, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h8, 32'h3C051234, "li");
        settle("li");
        check("seq_wordCount", 32'(word_count), 32'd3);
        pulse_clear();

        // Forced-zero fields: SLL drops rs, JR drops rt/rd.
        send(MN_SLL, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b1, 32'h0, 32'h00031100, "sll");
        send(MN_JR, 5'd31, 5'd5, 5'd5, 5'd0, 16'h0, 26'h0, 1'b1, 32'h4, 32'h03E00008, "jr");
        settle("jr");

        // Illegal mnemonic: one-cycle errPulse, no write, IDLE two cycles later.
        send(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 32'h0, 32'h0, "illegal");
        @(negedge clk);
        check("illegal_err_c1", 32'(err_pulse), 32'd0);
        check("illegal_ready_c1", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("illegal_err_c2", 32'(err_pulse), 32'd1);
        check("illegal_ready_c2", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("illegal_err_c3", 32'(err_pulse), 32'd0);
        check("illegal_wordCount", 32'(word_count), 32'd2);

        // Fill to DEPTH; shamt on OR-class is ignored, ADDI/BEQ fill words 2 and 3.
        send(MN_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1, 32'h8, 32'h2022FFFF, "addi");
        send(MN_BEQ, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b1, 32'hC, 32'h10640010, "beq");
        settle("beq");
        check("full_flag", 32'(full), 32'd1);
        check("full_inReady", 32'(in_ready), 32'd0);
        check("full_wordCount", 32'(word_count), 32'd4);

        // A fifth request must not be accepted while FULL.
        in_valid = 1'b1;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_ready) hits++;
        end
        check("full_no_transfer", 32'(hits), 32'd0);
        check("full_hold_wordCount", 32'(word_count), 32'd4);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        check("full_clear_state", 32'(full), 32'd0);
        check("full_clear_wordCount", 32'(word_count), 32'd0);
        send(MN_OR, 5'd4, 5'd5, 5'd6, 5'd5, 16'h0, 26'h0, 1'b1, 32'h0, 32'h00853025, "or");
        settle("or");

        // Reset asserted mid-WRITE drops memWe without a clock edge.
        send(MN_MULT, 5'd2, 5'd3, 5'd7, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0, 32'h0, "mult_abort");
        @(posedge clk);
        #2;
        check("midwrite_memWe_before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midwrite_memWe_after", 32'(mem_we), 32'd0);
        check("midwrite_wordCount", 32'(word_count), 32'd0);
        check("midwrite_memAddr", mem_addr, 32'h0);
        check("midwrite_inReady", 32'(in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        send(MN_MULT, 5'd2, 5'd3, 5'd7, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0, 32'h00430018, "mult");
        settle("mult");
        check("post_reset_wordCount", 32'(word_count), 32'd1);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control/decode path: turns symbolic instructions into 32-bit MIPS machine words and writes them sequentially into instruction memory.
- Inputs are a mnemonic code plus register, shift, immediate and target fields.
- Sits between a host/boot port and the instruction memory write port, so the single-cycle core can be loaded without a preassembled image.
- Handles the full instruction set the core's control unit decodes, including li, jal, jr, sll and srl.

Parameters:
- DEPTH, 256, number of instruction words the loader may write before it reports full.
- BASE_ADDR, 32'h0, byte address of the first word written.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inValid  in  1  host presents an instruction.
- inReady  out  1  loader accepts the instruction this cycle.
- mnem  in  5  mnemonic code (see Decomposition); 20..31 are illegal.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- imm  in  16  immediate or branch word offset, placed verbatim.
- target  in  26  jump target field, placed verbatim.
- clear  in  1  synchronous restart: pointer back to BASE_ADDR, leaves FULL.
- memWe  out  1  instruction memory write strobe, one cycle per word.
- memAddr  out  32  byte address of the write.
- memData  out  32  encoded instruction word.
- wordCount  out  $clog2(DEPTH+1)  number of words written since reset or clear.
- errPulse  out  1  one-cycle pulse when an illegal mnemonic is dropped.
- full  out  1  high while in FULL.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pointer=BASE_ADDR.
  - memWe=0, memAddr=BASE_ADDR, memData=0.
  - wordCount=0, errPulse=0, full=0, inReady=0 while rst_n low.
  - Reset asserted mid-WRITE drops memWe immediately.
- inReady is high only when state is IDLE and clear is low. A transfer occurs when inValid and inReady are both high; fields are registered on that edge.
- FSM states:
  - IDLE -> ENC on transfer.
  - ENC: compute the word from the registered fields. A legal mnemonic goes to WRITE. An illegal mnemonic goes back to IDLE, pulses errPulse for one cycle and writes nothing.
  - WRITE: memWe=1 for exactly one cycle with memAddr=pointer and memData=word. Then pointer+=4 and wordCount+=1. Go to FULL if wordCount reaches DEPTH, else IDLE.
  - FULL: inReady=0 and full=1. clear returns to IDLE with pointer=BASE_ADDR and wordCount=0.
- clear behaviour by state:
  - In IDLE: same reset of pointer and wordCount.
  - In ENC or WRITE: ignored until the FSM reaches IDLE or FULL; the in-flight word completes.
- Latency: transfer at edge N; memWe high during cycle N+2. Throughput is one word per 3 cycles.
- memAddr and memData hold their last values when memWe=0.
- Encoding: {op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], func[5:0]}.
  - R-type (AND, SUB, ADD, OR, SLT, MULT, JR, SLL, SRL): op=0; func values 100100, 100010, 100000, 100101, 101010, 011000, 001000, 000000, 000010.
  - Forced zero fields: shamt=0 except SLL/SRL; rs=0 for SLL/SRL; rt=rd=0 for JR; rd=0 for MULT.
  - I-type {op, rs, rt, imm}: LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, LI 001111 (rs forced 0).
  - J-type {op, target}: J 000010, JAL 000011.
- Pointer wraps never occur; FULL blocks further writes.

Decomposition:
- Shared package (header of localparams) holds:
  - mnemonic codes: AND=0, SUB=1, ADD=2, OR=3, SLT=4, MULT=5, JR=6, SLL=7, SRL=8, LW=9, SW=10, BEQ=11, BNE=12, J=13, JAL=14, ADDI=15, ANDI=16, ORI=17, SLTI=18, LI=19;
  - opcode and func constants, shared with control;
  - FSM state encodings.
- Sub-module instr_word_packer: combinational, mnemonic plus fields in, {word, legal} out, instantiated in ENC.

Test Plan:
- ADD rs=1 rt=2 rd=3 -> one memWe at cycle N+2, memAddr=0, memData=32'h00221820, wordCount=1.
- LW rs=29 rt=8 imm=4, then J target=26'h10, then LI rt=5 imm=16'h1234 -> data 8FA80004, 08000010, 3C051234 at addresses 0, 4, 8.
- SLL rs=7 rt=3 rd=2 shamt=4 -> 32'h00031100 (rs forced 0); JR rs=31 rt=5 rd=5 -> 32'h03E00008.
- mnem=25 -> errPulse one cycle, no memWe, wordCount unchanged, inReady high again 2 cycles after the transfer.
- DEPTH=4: write 4 words -> full=1, inReady=0, a fifth inValid gets no transfer. clear -> IDLE, next word written at address 0.
- rst_n low during WRITE -> memWe falls with no clock edge. After release: wordCount=0, pointer=BASE_ADDR.
